// File: rtl/mskand_hpc2_sched_pkg.sv
// Shared sizing helpers for the HPC2 AND scheduler and its gadget.
package mskand_hpc2_sched_pkg;

    function automatic int nrnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of the random bit shared by share pair (i, j), i < j, in the rnd vector.
    function automatic int rnd_idx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/mskand_hpc2_sched_gadget.sv
// HPC2 masked AND gadget: inb/rnd enter at cycle t, ina at t+1, out_c valid at t+2.
module MSKand_HPC2
    import mskand_hpc2_sched_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                  clk,
    input  logic [d-1:0]          ina,
    input  logic [d-1:0]          inb,
    input  logic [nrnd(d)-1:0]    rnd,
    output logic [d-1:0]          out_c
);
    localparam int NR = nrnd(d);

    logic [NR-1:0]  rnd_reg;
    logic [d-1:0]   inb_reg;
    logic [d*d-1:0] term;

    always_ff @(posedge clk) begin
        rnd_reg <= rnd;
        inb_reg <= inb;
    end

    generate
        for (genvar gi = 0; gi < d; gi++) begin : g_row
            logic ab_reg;

            always_ff @(posedge clk) begin
                ab_reg <= ina[gi] & inb_reg[gi];
            end

            for (genvar gj = 0; gj < d; gj++) begin : g_col
                if (gi != gj) begin : g_pair
                    localparam int K = (gi < gj) ? rnd_idx(gi, gj, d) : rnd_idx(gj, gi, d);
                    logic v_reg;
                    logic u_reg;
                    logic w_reg;

                    // r_ij is shared by (i,j) and (j,i), so the pair terms cancel in the XOR of all shares.
                    always_ff @(posedge clk) begin
                        v_reg <= inb[gj] ^ rnd[K];
                        u_reg <= ~ina[gi] & rnd_reg[K];
                        w_reg <= ina[gi] & v_reg;
                    end

                    assign term[gi*d + gj] = u_reg ^ w_reg;
                end else begin : g_diag
                    assign term[gi*d + gj] = 1'b0;
                end
            end

            assign out_c[gi] = ab_reg ^ (^term[gi*d +: d]);
        end
    endgenerate

endmodule

// File: rtl/mskand_hpc2_sched.sv
// Round-robin scheduler sharing one HPC2 AND gadget among NREQ requesters, fixed latency 2.
module mskand_hpc2_sched
    import mskand_hpc2_sched_pkg::*;
#(
    parameter int D    = 2,
    parameter int NREQ = 2,
    localparam int NRND = nrnd(D),
    localparam int IDW  = idw(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*D-1:0]   req_a,
    input  logic [NREQ*D-1:0]   req_b,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    input  logic [NRND-1:0]     rnd_data,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [D-1:0]        res_c,
    output logic                busy
);
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t            stage0_reg;
    tag_t            stage1_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [IDW-1:0]  rr_ptr_next;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_found;
    logic            issue;
    logic [D-1:0]    a_hold_reg;
    logic [D-1:0]    gadget_ina;
    logic [D-1:0]    gadget_inb;
    logic [D-1:0]    gadget_c;
    logic [NRND-1:0] gadget_rnd;

    // Walk the requesters starting at rr_ptr and take the first one asserting req_valid.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = rr_ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign issue       = !rst && rnd_valid && grant_found;
    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = issue && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign rnd_ready  = issue;
    assign gadget_inb = issue ? req_b[grant_idx*D +: D] : '0;
    assign gadget_rnd = issue ? rnd_data : '0;
    assign gadget_ina = stage0_reg.valid ? a_hold_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            stage0_reg <= '0;
            stage1_reg <= '0;
            a_hold_reg <= '0;
        end else begin
            stage1_reg <= stage0_reg;
            if (issue) begin
                stage0_reg <= '{valid: 1'b1, id: grant_idx};
                a_hold_reg <= req_a[grant_idx*D +: D];
                rr_ptr_reg <= rr_ptr_next;
            end else begin
                stage0_reg <= '0;
                a_hold_reg <= '0;
            end
        end
    end

    MSKand_HPC2 #(.d(D)) u_gadget (
        .clk   (clk),
        .ina   (gadget_ina),
        .inb   (gadget_inb),
        .rnd   (gadget_rnd),
        .out_c (gadget_c)
    );

    assign res_valid = stage1_reg.valid;
    assign res_id    = stage1_reg.id;
    assign res_c     = gadget_c;
    assign busy      = stage0_reg.valid | stage1_reg.valid;

endmodule

// File: tb/tb_mskand_hpc2_sched.sv
// Randomized bench for mskand_hpc2_sched against a queue-based transaction model.
module tb_mskand_hpc2_sched;
    import mskand_hpc2_sched_pkg::*;

    localparam int D    = 2;
    localparam int NREQ = 2;
    localparam int NRND = nrnd(D);
    localparam int IDW  = idw(NREQ);

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*D-1:0]   req_a;
    logic [NREQ*D-1:0]   req_b;
    logic                rnd_valid;
    logic                rnd_ready;
    logic [NRND-1:0]     rnd_data;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [D-1:0]        res_c;
    logic                busy;

    mskand_hpc2_sched #(.D(D), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_data  (rnd_data),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_c     (res_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        bit prod;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    int           rr_model = 0;
    logic [D-1:0] prev_a   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Random sharing of one unmasked bit.
    function automatic logic [D-1:0] mk_shares(input bit val);
        logic [D-1:0] s;
        s = D'($urandom);
        s[D-1] = val ^ (^s[D-2:0]);
        return s;
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic rv, input logic do_rst,
                        input logic [NREQ*D-1:0] av, input logic [NREQ*D-1:0] bv,
                        input logic [NRND-1:0] rd);
        int              g;
        bit              iss;
        exp_t            e;
        logic [NREQ-1:0] exp_rdy;
        logic [D-1:0]    exp_inb;
        logic [NRND-1:0] exp_rnd;
        @(negedge clk);
        rst       = do_rst;
        req_valid = v;
        rnd_valid = rv;
        req_a     = av;
        req_b     = bv;
        rnd_data  = rd;
        #1;
        iss = 1'b0;
        g   = 0;
        if (!do_rst && rv) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (rr_model + k) % NREQ;
                if (!iss && v[c]) begin
                    iss = 1'b1;
                    g   = c;
                end
            end
        end
        exp_rdy = '0;
        exp_inb = '0;
        exp_rnd = '0;
        if (iss) begin
            exp_rdy[g] = 1'b1;
            exp_inb    = bv[g*D +: D];
            exp_rnd    = rd;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rnd_ready", 32'(rnd_ready), 32'(iss));
        check("gadget_ina", 32'(dut.gadget_ina), 32'(prev_a));
        check("gadget_inb", 32'(dut.gadget_inb), 32'(exp_inb));
        check("gadget_rnd", 32'(dut.gadget_rnd), 32'(exp_rnd));
        prev_a = '0;
        if (iss) begin
            e.due  = cyc + 2;
            e.id   = g;
            e.prod = (^av[g*D +: D]) & (^bv[g*D +: D]);
            exp_q.push_back(e);
            rr_model = (g + 1) % NREQ;
            prev_a   = av[g*D +: D];
            $display("cycle %0d issue: req %0d a=%0b b=%0b rnd=%0b", cyc, g, av[g*D +: D], bv[g*D +: D], rd);
        end
        if (do_rst) begin
            exp_q.delete();
            rr_model = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (do_rst) check("res_id_after_rst", 32'(res_id), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("res_valid", 32'(res_valid), 32'd1);
            check("res_id", 32'(res_id), 32'(e.id));
            check("res_c_xor", 32'(^res_c), 32'(e.prod));
            $display("cycle %0d result: id=%0d c=%0b expected product %0d", cyc, res_id, res_c, e.prod);
        end else begin
            check("res_valid_idle", 32'(res_valid), 32'd0);
        end
    endtask

    task automatic rand_step(input logic [NREQ-1:0] v, input logic rv, input logic do_rst);
        logic [NREQ*D-1:0] av;
        logic [NREQ*D-1:0] bv;
        for (int i = 0; i < NREQ; i++) begin
            av[i*D +: D] = mk_shares(1'($urandom));
            bv[i*D +: D] = mk_shares(1'($urandom));
        end
        step(v, rv, do_rst, av, bv, NRND'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rand_step('0, 1'($urandom), 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rnd_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rnd_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);

        // Single directed AND: a=(1,0), b=(0,1), rnd=1 -> product 1 from requester 0.
        step(2'b01, 1'b1, 1'b0, {2'b00, 2'b01}, {2'b00, 2'b10}, NRND'(1));
        idle(3);

        // Realign rotation to 0, then both requesters contend for 4 cycles.
        rand_step(2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) rand_step(2'b11, 1'b1, 1'b0);
        idle(2);

        // Randomness starvation stalls a waiting requester.
        for (int i = 0; i < 3; i++) rand_step(2'b01, 1'b0, 1'b0);
        rand_step(2'b01, 1'b1, 1'b0);
        idle(2);

        // Every unmasked a,b combination with fresh share splits, back-to-back.
        for (int ab = 0; ab < 4; ab++) begin
            for (int rep = 0; rep < 4; rep++) begin
                logic [NREQ*D-1:0] av;
                logic [NREQ*D-1:0] bv;
                logic [NREQ-1:0]   v;
                for (int i = 0; i < NREQ; i++) begin
                    av[i*D +: D] = mk_shares(ab[1]);
                    bv[i*D +: D] = mk_shares(ab[0]);
                end
                v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                step(v, 1'b1, 1'b0, av, bv, NRND'($urandom));
            end
        end
        idle(2);

        // Reset right after an issue drops that result and restarts rotation at 0.
        rand_step(2'b01, 1'b1, 1'b0);
        rand_step(2'b11, 1'b1, 1'b1);
        rand_step('0, 1'b1, 1'b0);
        rand_step(2'b11, 1'b1, 1'b0);
        idle(2);

        // Random traffic with occasional stalls, idles and resets.
        for (int i = 0; i < 200; i++) begin
            rand_step(NREQ'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0);
        end
        idle(3);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
